// File: rtl/sem_mailbox_pkg.sv
// Shared defaults and helpers for the multi-channel semaphore mailbox.
package sem_mailbox_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_NUM_CH     = 2;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sem_mailbox_if.sv
// Semaphore bus between CPU cores and the mailbox; master = cores, slave = mailbox.
interface sem_mailbox_if
  import sem_mailbox_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned CH_W       = ch_width(NUM_CH)
) ();

  logic [DATA_WIDTH-1:0] sem_data_in;
  logic [CH_W-1:0]       sem_ch_in;
  logic                  sem_data_valid_in;
  logic                  sem_data_ready;
  logic                  sem_data_read;
  logic [CH_W-1:0]       sem_ch_read;
  logic [DATA_WIDTH-1:0] sem_data_out;
  logic                  sem_data_valid_out;
  logic [NUM_CH-1:0]     sem_data_empty;
  logic [NUM_CH-1:0]     sem_data_full;
  logic                  sem_overflow;
  logic                  sem_underflow;
  logic                  sem_err_clr;

  modport master (
    output sem_data_in, sem_ch_in, sem_data_valid_in, sem_data_read,
           sem_ch_read, sem_err_clr,
    input  sem_data_ready, sem_data_out, sem_data_valid_out, sem_data_empty,
           sem_data_full, sem_overflow, sem_underflow
  );

  modport slave (
    input  sem_data_in, sem_ch_in, sem_data_valid_in, sem_data_read,
           sem_ch_read, sem_err_clr,
    output sem_data_ready, sem_data_out, sem_data_valid_out, sem_data_empty,
           sem_data_full, sem_overflow, sem_underflow
  );

endinterface

// File: rtl/sem_mailbox_ch_fifo.sv
// Single-channel FIFO: storage, wrapping pointers and occupancy count.
module sem_ch_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/sem_mailbox.sv
// Multi-channel semaphore mailbox: channel decode, read mux, output register, sticky errors.
module sem_mailbox
  import sem_mailbox_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned NUM_CH     = DEF_NUM_CH
) (
  input logic         clk,
  input logic         rst,
  sem_mailbox_if.slave bus
);

  localparam int unsigned CH_W  = ch_width(NUM_CH);
  localparam int unsigned SLOTS = 2 ** CH_W;

  // Unpopulated select codes read as full+empty, so out-of-range requests
  // are rejected by the same logic that rejects full/empty channels.
  logic [SLOTS-1:0]      empty_pad;
  logic [SLOTS-1:0]      full_pad;
  logic [DATA_WIDTH-1:0] ch_rdata [SLOTS];

  logic                  wr_ok, wr_rej, rd_ok, rd_rej;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  err_flags_t            err_q;

  assign bus.sem_data_ready = !full_pad[bus.sem_ch_in];

  assign wr_ok  = bus.sem_data_valid_in && bus.sem_data_ready;
  assign wr_rej = bus.sem_data_valid_in && !bus.sem_data_ready;
  assign rd_ok  = bus.sem_data_read && !empty_pad[bus.sem_ch_read];
  assign rd_rej = bus.sem_data_read && empty_pad[bus.sem_ch_read];

  for (genvar i = 0; i < SLOTS; i++) begin : g_ch
    if (i < NUM_CH) begin : g_fifo
      sem_ch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_ok && (bus.sem_ch_in == CH_W'(i))),
        .pop   (rd_ok && (bus.sem_ch_read == CH_W'(i))),
        .wdata (bus.sem_data_in),
        .rdata (ch_rdata[i]),
        .empty (empty_pad[i]),
        .full  (full_pad[i])
      );
    end else begin : g_unused
      assign ch_rdata[i]  = '0;
      assign empty_pad[i] = 1'b1;
      assign full_pad[i]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      valid_q <= rd_ok;
      if (rd_ok) data_q <= ch_rdata[bus.sem_ch_read];
      err_q.overflow  <= wr_rej || (err_q.overflow  && !bus.sem_err_clr);
      err_q.underflow <= rd_rej || (err_q.underflow && !bus.sem_err_clr);
    end
  end

  assign bus.sem_data_out       = data_q;
  assign bus.sem_data_valid_out = valid_q;
  assign bus.sem_data_empty     = empty_pad[NUM_CH-1:0];
  assign bus.sem_data_full      = full_pad[NUM_CH-1:0];
  assign bus.sem_overflow       = err_q.overflow;
  assign bus.sem_underflow      = err_q.underflow;

endmodule
